// File: rtl/seven_segment_decoder_if.sv
// Bus between a multiplexed seven-segment source and the decoder.
// The master drives the segment and digit-select lines; the slave returns the published number and status pulses.
interface seven_segment_decoder_if;
  logic [6:0] segments;
  logic       digit;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       valid;
  logic       code_err;
  logic       seq_err;
  logic [6:0] value;

  modport master (
    output segments, digit,
    input  ten_count, unit_count, valid, code_err, seq_err, value
  );

  modport slave (
    input  segments, digit,
    output ten_count, unit_count, valid, code_err, seq_err, value
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// Decodes a two-digit multiplexed seven-segment stream and publishes it after MATCH_FRAMES identical frames.
// Define SEG_DECODE_BINARY_EN to also register the binary value ten*10+unit on bus.value.
module seven_segment_decoder #(
  parameter int unsigned MATCH_FRAMES = 2
) (
  input logic clk,
  input logic reset,
  seven_segment_decoder_if.slave bus
);

  typedef enum logic {WAIT_UNIT, WAIT_TEN} state_t;

  localparam logic [3:0] MATCH_TARGET = 4'(MATCH_FRAMES);

  state_t     state;
  logic [6:0] seg_q;
  logic       digit_q;
  logic       sample_ok;
  logic [3:0] code;
  logic       code_ok;
  logic [3:0] unit_cand;
  logic [3:0] prev_ten;
  logic [3:0] prev_unit;
  logic [3:0] match_cnt;
  logic [3:0] cnt_next;
  logic       same_pair;
  logic       frame_done;
  logic       publish;
  logic [3:0] ten_q;
  logic [3:0] unit_q;
  logic       valid_q;
  logic       code_err_q;
  logic       seq_err_q;

  // sample_ok hides the reset value of the sample stage so release never yields a spurious code_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q     <= '0;
      digit_q   <= 1'b0;
      sample_ok <= 1'b0;
    end else begin
      seg_q     <= bus.segments;
      digit_q   <= bus.digit;
      sample_ok <= 1'b1;
    end
  end

  always_comb begin
    code    = 4'd0;
    code_ok = 1'b1;
    case (seg_q)
      7'b0111111: code = 4'd0;
      7'b0000110: code = 4'd1;
      7'b1011011: code = 4'd2;
      7'b1001111: code = 4'd3;
      7'b1100110: code = 4'd4;
      7'b1101101: code = 4'd5;
      7'b1111100: code = 4'd6;
      7'b0000111: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1100111: code = 4'd9;
      default:    code_ok = 1'b0;
    endcase
  end

  // A new pair always restarts at one, so MATCH_FRAMES=1 publishes on any change of number
  always_comb begin
    same_pair  = (code == prev_ten) && (unit_cand == prev_unit);
    frame_done = sample_ok && code_ok && (state == WAIT_TEN) && digit_q;
    if (!same_pair) begin
      cnt_next = 4'd1;
    end else if (match_cnt >= MATCH_TARGET) begin
      cnt_next = match_cnt;
    end else begin
      cnt_next = match_cnt + 4'd1;
    end
    publish = (cnt_next == MATCH_TARGET) && (!same_pair || (match_cnt != MATCH_TARGET));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_UNIT;
      unit_cand  <= '0;
      prev_ten   <= '0;
      prev_unit  <= '0;
      match_cnt  <= '0;
      ten_q      <= '0;
      unit_q     <= '0;
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
      if (sample_ok) begin
        if (!code_ok) begin
          code_err_q <= 1'b1;
          seq_err_q  <= (state == WAIT_TEN) && !digit_q;
          match_cnt  <= '0;
          state      <= WAIT_UNIT;
        end else begin
          case (state)
            WAIT_UNIT: begin
              if (!digit_q) begin
                unit_cand <= code;
                state     <= WAIT_TEN;
              end
            end
            WAIT_TEN: begin
              if (digit_q) begin
                state     <= WAIT_UNIT;
                match_cnt <= cnt_next;
                if (!same_pair) begin
                  prev_ten  <= code;
                  prev_unit <= unit_cand;
                end
                if (publish) begin
                  ten_q   <= code;
                  unit_q  <= unit_cand;
                  valid_q <= 1'b1;
                end
              end else begin
                seq_err_q <= 1'b1;
                unit_cand <= code;
              end
            end
          endcase
        end
      end
    end
  end

`ifdef SEG_DECODE_BINARY_EN
  logic [6:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (frame_done && publish) begin
      value_q <= ({3'd0, code} << 3) + ({3'd0, code} << 1) + {3'd0, unit_cand};
    end
  end

  assign bus.value = value_q;
`else
  assign bus.value = 7'd0;
`endif

  assign bus.ten_count  = ten_q;
  assign bus.unit_count = unit_q;
  assign bus.valid      = valid_q;
  assign bus.code_err   = code_err_q;
  assign bus.seq_err    = seq_err_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench for seven_segment_decoder: one instance with MATCH_FRAMES=2, one with MATCH_FRAMES=1.
// Expected pulses are queued with the cycle they must appear on; monitors pop them when the DUT pulses.
module tb_seven_segment_decoder;

  typedef struct {
    int   cyc;
    logic v;
    logic ce;
    logic se;
    int   ten;
    int   unit;
  } exp_t;

  localparam logic [6:0] BAD_SEG = 7'b1111110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   drive_cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  seven_segment_decoder_if bus0 ();
  seven_segment_decoder_if bus1 ();

  seven_segment_decoder #(.MATCH_FRAMES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seven_segment_decoder #(.MATCH_FRAMES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111100;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1100111;
    endcase
  endfunction

  function automatic int exp_value(input int ten, input int unit);
`ifdef SEG_DECODE_BINARY_EN
    return ten * 10 + unit;
`else
    return 0 * (ten + unit);
`endif
  endfunction

  task automatic check_output(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] seg, input logic dig);
    @(negedge clk);
    bus0.segments = seg;
    bus0.digit    = dig;
    bus1.segments = seg;
    bus1.digit    = dig;
    drive_cyc     = cyc;
  endtask

  task automatic send_frame(input int unit, input int ten);
    apply_stimulus(seg_of(unit), 1'b0);
    apply_stimulus(seg_of(ten), 1'b1);
  endtask

  task automatic exp0(input logic v, input logic ce, input logic se, input int ten = 0, input int unit = 0);
    exp_t e;
    e.cyc = drive_cyc + 2; e.v = v; e.ce = ce; e.se = se; e.ten = ten; e.unit = unit;
    q0.push_back(e);
  endtask

  task automatic exp1(input logic v, input logic ce, input logic se, input int ten = 0, input int unit = 0);
    exp_t e;
    e.cyc = drive_cyc + 2; e.v = v; e.ce = ce; e.se = se; e.ten = ten; e.unit = unit;
    q1.push_back(e);
  endtask

  task automatic compare_event(input string tag, input exp_t e, input logic v, input logic ce,
                               input logic se, input logic [3:0] t, input logic [3:0] u,
                               input logic [6:0] val);
    check_output({tag, " event cycle"}, cyc, e.cyc);
    check_output({tag, " valid"}, int'(v), int'(e.v));
    check_output({tag, " code_err"}, int'(ce), int'(e.ce));
    check_output({tag, " seq_err"}, int'(se), int'(e.se));
    if (e.v) begin
      check_output({tag, " ten_count"}, int'(t), e.ten);
      check_output({tag, " unit_count"}, int'(u), e.unit);
      check_output({tag, " value"}, int'(val), exp_value(e.ten, e.unit));
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int ten, input int unit);
    check_output({tag, " d0 ten_count"}, int'(bus0.ten_count), ten);
    check_output({tag, " d0 unit_count"}, int'(bus0.unit_count), unit);
    check_output({tag, " d0 value"}, int'(bus0.value), exp_value(ten, unit));
    check_output({tag, " d1 ten_count"}, int'(bus1.ten_count), ten);
    check_output({tag, " d1 unit_count"}, int'(bus1.unit_count), unit);
    check_output({tag, " d1 value"}, int'(bus1.value), exp_value(ten, unit));
  endtask

  task automatic check_all_zero(input string tag);
    check_idle_outputs(tag, 0, 0);
    check_output({tag, " d0 pulses"}, int'({bus0.valid, bus0.code_err, bus0.seq_err}), 0);
    check_output({tag, " d1 pulses"}, int'({bus1.valid, bus1.code_err, bus1.seq_err}), 0);
  endtask

  // Any pulse cycle must match the next queued expectation, including the cycle it was due on
  always @(negedge clk) begin
    if (!reset && (bus0.valid || bus0.code_err || bus0.seq_err)) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL d0 unexpected pulse: got v=%0b ce=%0b se=%0b at cycle %0d, required none",
                 bus0.valid, bus0.code_err, bus0.seq_err, cyc);
      end else begin
        e0 = q0.pop_front();
        compare_event("d0", e0, bus0.valid, bus0.code_err, bus0.seq_err,
                      bus0.ten_count, bus0.unit_count, bus0.value);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (bus1.valid || bus1.code_err || bus1.seq_err)) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL d1 unexpected pulse: got v=%0b ce=%0b se=%0b at cycle %0d, required none",
                 bus1.valid, bus1.code_err, bus1.seq_err, cyc);
      end else begin
        e1 = q1.pop_front();
        compare_event("d1", e1, bus1.valid, bus1.code_err, bus1.seq_err,
                      bus1.ten_count, bus1.unit_count, bus1.value);
      end
    end
  end

  initial begin
    bus0.segments = seg_of(8);
    bus0.digit    = 1'b1;
    bus1.segments = seg_of(8);
    bus1.digit    = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Three 42 frames: publish after frame 2 (MF=2) or frame 1 (MF=1)
    for (int i = 0; i < 3; i++) begin
      send_frame(2, 4);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 4, 2);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 4, 2);
    end

    for (int i = 0; i < 2; i++) begin
      send_frame(9, 9);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 9, 9);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 9, 9);
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("after 99", 9, 9);

    apply_stimulus(BAD_SEG, 1'b0);
    exp0(1'b0, 1'b1, 1'b0);
    exp1(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_frame(2, 4);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 4, 2);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 4, 2);
    end

    // Same pair after a code error must count up from zero again
    apply_stimulus(BAD_SEG, 1'b0);
    exp0(1'b0, 1'b1, 1'b0);
    exp1(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_frame(2, 4);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 4, 2);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 4, 2);
    end

    apply_stimulus(seg_of(2), 1'b0);
    apply_stimulus(BAD_SEG, 1'b0);
    exp0(1'b0, 1'b1, 1'b1);
    exp1(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      send_frame(2, 4);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 4, 2);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 4, 2);
    end

    for (int i = 0; i < 2; i++) begin
      apply_stimulus(seg_of(3), 1'b0);
      apply_stimulus(seg_of(5), 1'b0);
      exp0(1'b0, 1'b0, 1'b1);
      exp1(1'b0, 1'b0, 1'b1);
      apply_stimulus(seg_of(1), 1'b1);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 1, 5);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 1, 5);
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("after 15", 1, 5);

    // Asynchronous reset while the FSM sits in WAIT_TEN, between clock edges
    apply_stimulus(seg_of(2), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus0.segments = seg_of(8);
    bus0.digit    = 1'b1;
    bus1.segments = seg_of(8);
    bus1.digit    = 1'b1;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 2; i++) begin
      send_frame(2, 4);
      if (i == 1) exp0(1'b1, 1'b0, 1'b0, 4, 2);
      if (i == 0) exp1(1'b1, 1'b0, 1'b0, 4, 2);
    end

    repeat (5) @(negedge clk);
    check_idle_outputs("final", 4, 2);
    check_output("d0 pending expectations", q0.size(), 0);
    check_output("d1 pending expectations", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
